// File: rtl/systolic_feed_ctrl.sv
// Feed sequencer for a 3x3 output-stationary systolic multiplier.
// Stores A/B, streams skewed edges, captures C with valid/ready.
module systolic_feed_ctrl #(
  parameter int DW    = 32,
  parameter int PW    = 64,
  parameter int DRAIN = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic          i_wr_sel,
  input  logic [3:0]    i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_arr_rst,
  output logic [DW-1:0] o_arr_a,
  output logic [DW-1:0] o_arr_b,
  output logic [DW-1:0] o_arr_c,
  output logic [DW-1:0] o_arr_d,
  output logic [DW-1:0] o_arr_e,
  output logic [DW-1:0] o_arr_f,
  input  logic [PW-1:0] i_arr_out1,
  input  logic [PW-1:0] i_arr_out2,
  input  logic [PW-1:0] i_arr_out3,
  input  logic [PW-1:0] i_arr_out4,
  input  logic [PW-1:0] i_arr_out5,
  input  logic [PW-1:0] i_arr_out6,
  input  logic [PW-1:0] i_arr_out7,
  input  logic [PW-1:0] i_arr_out8,
  input  logic [PW-1:0] i_arr_out9,
  output logic          o_res_valid,
  input  logic          i_res_ready,
  output logic [PW-1:0] o_res_c1,
  output logic [PW-1:0] o_res_c2,
  output logic [PW-1:0] o_res_c3,
  output logic [PW-1:0] o_res_c4,
  output logic [PW-1:0] o_res_c5,
  output logic [PW-1:0] o_res_c6,
  output logic [PW-1:0] o_res_c7,
  output logic [PW-1:0] o_res_c8,
  output logic [PW-1:0] o_res_c9
);

  localparam int CW = $clog2(DRAIN + 5) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_busy;
  logic          w_busy_nxt;
  logic          r_valid;
  logic          w_valid_nxt;
  logic          w_cap;
  logic          r_arr_rst;
  logic [DW-1:0] r_a [9];
  logic [DW-1:0] r_b [9];
  logic [DW-1:0] r_el [3];
  logic [DW-1:0] r_et [3];
  logic [DW-1:0] w_el [3];
  logic [DW-1:0] w_et [3];
  logic [PW-1:0] r_res [9];
  logic [PW-1:0] w_out [9];
  logic          w_wr_ok;

  assign w_out = '{i_arr_out1, i_arr_out2, i_arr_out3,
                   i_arr_out4, i_arr_out5, i_arr_out6,
                   i_arr_out7, i_arr_out8, i_arr_out9};

  assign w_wr_ok = i_wr_en && !r_busy &&
                   (i_wr_addr <= 4'd8);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_valid_nxt = r_valid;
    w_cap       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start && !r_valid) begin
          w_state_nxt = S_CLEAR;
          w_busy_nxt  = 1'b1;
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_FEED;
        w_cnt_nxt   = '0;
      end
      S_FEED: begin
        if (r_cnt == CW'(4)) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (r_cnt == CW'(DRAIN - 1)) begin
          w_state_nxt = S_DONE;
          w_cap       = 1'b1;
          w_busy_nxt  = 1'b0;
          w_valid_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        if (i_res_ready) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Edges are registered, so they are computed for the next feed step.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_el[i] = '0;
      w_et[i] = '0;
      if (w_state_nxt == S_FEED &&
          int'(w_cnt_nxt) >= i &&
          int'(w_cnt_nxt) - i <= 2) begin
        w_el[i] = r_a[4'(2 * i + int'(w_cnt_nxt))];
        w_et[i] = r_b[4'(3 * (int'(w_cnt_nxt) - i) + i)];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_arr_rst <= 1'b1;
      for (int i = 0; i < 9; i++) begin
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_res[i] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        r_el[i] <= '0;
        r_et[i] <= '0;
      end
    end else begin
      r_arr_rst <= (w_state_nxt == S_CLEAR);
      r_el      <= w_el;
      r_et      <= w_et;
      if (w_cap) r_res <= w_out;
      if (w_wr_ok) begin
        if (i_wr_sel) r_b[i_wr_addr] <= i_wr_data;
        else          r_a[i_wr_addr] <= i_wr_data;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_res_valid = r_valid;
  assign o_arr_rst   = r_arr_rst;
  assign o_arr_a     = r_el[0];
  assign o_arr_b     = r_el[1];
  assign o_arr_c     = r_el[2];
  assign o_arr_d     = r_et[0];
  assign o_arr_e     = r_et[1];
  assign o_arr_f     = r_et[2];
  assign o_res_c1    = r_res[0];
  assign o_res_c2    = r_res[1];
  assign o_res_c3    = r_res[2];
  assign o_res_c4    = r_res[3];
  assign o_res_c5    = r_res[4];
  assign o_res_c6    = r_res[5];
  assign o_res_c7    = r_res[6];
  assign o_res_c8    = r_res[7];
  assign o_res_c9    = r_res[8];

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl with a behavioural 3x3 array
// and a matrix-product reference computed from the stored operands.
module tb_systolic_feed_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic        res_ready = 1'b0;
  logic        busy, arr_rst, res_valid;
  logic [31:0] arr_a, arr_b, arr_c, arr_d, arr_e, arr_f;
  logic [63:0] res_c [9];

  logic [31:0] ea [3];
  logic [31:0] eb [3];
  logic [31:0] ah [3][3];
  logic [31:0] bv [3][3];
  logic [63:0] acc [3][3];

  logic [31:0] ma [9];
  logic [31:0] mb [9];
  logic [63:0] expc [9];

  int checks = 0;
  int errors = 0;
  int n, n2;

  always #5 clk = ~clk;

  systolic_feed_ctrl dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_en(wr_en), .i_wr_sel(wr_sel),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_start(start), .o_busy(busy), .o_arr_rst(arr_rst),
    .o_arr_a(arr_a), .o_arr_b(arr_b), .o_arr_c(arr_c),
    .o_arr_d(arr_d), .o_arr_e(arr_e), .o_arr_f(arr_f),
    .i_arr_out1(acc[0][0]), .i_arr_out2(acc[0][1]),
    .i_arr_out3(acc[0][2]), .i_arr_out4(acc[1][0]),
    .i_arr_out5(acc[1][1]), .i_arr_out6(acc[1][2]),
    .i_arr_out7(acc[2][0]), .i_arr_out8(acc[2][1]),
    .i_arr_out9(acc[2][2]),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_c1(res_c[0]), .o_res_c2(res_c[1]),
    .o_res_c3(res_c[2]), .o_res_c4(res_c[3]),
    .o_res_c5(res_c[4]), .o_res_c6(res_c[5]),
    .o_res_c7(res_c[6]), .o_res_c8(res_c[7]),
    .o_res_c9(res_c[8])
  );

  always_comb begin
    ea = '{arr_a, arr_b, arr_c};
    eb = '{arr_d, arr_e, arr_f};
  end

  function automatic logic [31:0] ain(int i, int j);
    return (j == 0) ? ea[i] : ah[i][(j + 2) % 3];
  endfunction

  function automatic logic [31:0] bin(int i, int j);
    return (i == 0) ? eb[j] : bv[(i + 2) % 3][j];
  endfunction

  // Output-stationary PE grid: a flows right, b flows down.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (arr_rst) begin
          ah[i][j]  <= '0;
          bv[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          ah[i][j]  <= ain(i, j);
          bv[i][j]  <= bin(i, j);
          acc[i][j] <= acc[i][j] +
                       64'(ain(i, j)) * 64'(bin(i, j));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic calc();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        expc[3*i+j] = '0;
        for (int k = 0; k < 3; k++)
          expc[3*i+j] += 64'(ma[3*i+k]) * 64'(mb[3*k+j]);
      end
  endtask

  function automatic logic [31:0] skew(bit side, int i, int t);
    int k;
    k = t - i;
    if (k < 0 || k > 2) return '0;
    return side ? mb[3*k+i] : ma[3*i+k];
  endfunction

  task automatic wr(bit sel, logic [3:0] addr,
                    logic [31:0] d);
    wr_en = 1'b1; wr_sel = sel;
    wr_addr = addr; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push();
    for (int k = 0; k < 9; k++) begin
      wr(1'b0, 4'(k), ma[k]);
      wr(1'b1, 4'(k), mb[k]);
    end
  endtask

  task automatic randomize_mats();
    for (int k = 0; k < 9; k++) begin
      ma[k] = $urandom;
      mb[k] = $urandom;
    end
  endtask

  task automatic start_job();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("clear_arr_rst", 64'(arr_rst), 64'd1);
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!res_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("valid_timeout", 64'(res_valid), 64'd1);
  endtask

  task automatic check_res(string tag);
    calc();
    for (int k = 0; k < 9; k++)
      chk($sformatf("%s_c%0d", tag, k + 1), res_c[k], expc[k]);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("hs_valid_low", 64'(res_valid), 64'd0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_arr_rst", 64'(arr_rst), 64'd1);
    chk("rst_arr_a", 64'(arr_a), 64'd0);
    chk("rst_res_c1", res_c[0], 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_arr_rst", 64'(arr_rst), 64'd0);

    for (int k = 0; k < 9; k++) begin
      ma[k] = 32'(k + 1);
      mb[k] = (k % 4 == 0) ? 32'd1 : 32'd0;
    end
    push();
    start_job();
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c < 10) begin
        chk($sformatf("t1_busy%0d", c), 64'(busy), 64'd1);
        chk($sformatf("t1_nv%0d", c), 64'(res_valid), 64'd0);
      end
    end
    chk("t1_valid10", 64'(res_valid), 64'd1);
    chk("t1_busy10", 64'(busy), 64'd0);
    check_res("t1");
    handshake();

    for (int k = 0; k < 9; k++) mb[k] = 32'(k + 11);
    for (int k = 0; k < 9; k++) wr(1'b1, 4'(k), mb[k]);
    start_job();
    tick();
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t2_L%0d_t%0d", i, t),
            64'(ea[i]), 64'(skew(1'b0, i, t)));
        chk($sformatf("t2_T%0d_t%0d", i, t),
            64'(eb[i]), 64'(skew(1'b1, i, t)));
      end
      chk("t2_feed_arr_rst", 64'(arr_rst), 64'd0);
      tick();
    end
    chk("t2_drain_a", 64'(arr_a), 64'd0);
    chk("t2_drain_f", 64'(arr_f), 64'd0);
    wait_valid(n);
    check_res("t2");
    handshake();

    for (int k = 0; k < 9; k++) begin
      ma[k] = 32'd2;
      mb[k] = 32'd3;
    end
    push();
    start_job();
    wait_valid(n);
    chk("t3_latency", 64'(n), 64'd10);
    for (int c = 0; c < 20; c++) begin
      start = (c == 5);
      wr_en = (c == 8);
      wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 32'd7;
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      chk("t3_hold_valid", 64'(res_valid), 64'd1);
      chk("t3_hold_busy", 64'(busy), 64'd0);
      for (int k = 0; k < 9; k++)
        chk("t3_hold_c", res_c[k], 64'd18);
    end
    ma[0] = 32'd7;
    handshake();
    start_job();
    wait_valid(n);
    check_res("t3_done_wr");
    handshake();

    randomize_mats();
    push();
    start_job();
    tick();
    tick();
    tick();
    wr_en = 1'b1; wr_sel = 1'b0;
    wr_addr = 4'd0; wr_data = 32'd99;
    start = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    chk("t4_busy", 64'(busy), 64'd1);
    wait_valid(n);
    chk("t4_latency", 64'(n + 4), 64'd10);
    check_res("t4");
    handshake();
    start_job();
    wait_valid(n);
    check_res("t4_rerun");
    handshake();

    randomize_mats();
    push();
    wr(1'b0, 4'd12, 32'hdead_beef);
    wr(1'b1, 4'd9, 32'h1234_5678);
    start_job();
    for (int c = 0; c < 7; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_valid", 64'(res_valid), 64'd0);
    chk("t5_arr_rst", 64'(arr_rst), 64'd1);
    chk("t5_arr_a", 64'(arr_a), 64'd0);
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("t5_no_valid", 64'(res_valid), 64'd0);
    end
    for (int k = 0; k < 9; k++) begin
      ma[k] = '0;
      mb[k] = '0;
    end
    start_job();
    wait_valid(n);
    check_res("t5_zero");
    handshake();

    randomize_mats();
    push();
    res_ready = 1'b1;
    start_job();
    wait_valid(n);
    chk("t6_lat1", 64'(n), 64'd10);
    check_res("t6_first");
    tick();
    chk("t6_idle_valid", 64'(res_valid), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(n2);
    chk("t6_gap", 64'(n2 + 2), 64'd12);
    check_res("t6_second");
    res_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
